// File: rtl/mem_access_unit_if.sv
// Core request/response and word-memory signals of the data-port initiator.
// master = core plus memory side, slave = mem_access_unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] d_addr;
  logic [31:0] rdata;
  logic        wen;
  logic [31:0] wmask;
  logic [31:0] wdata;

  modport master (
    output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned, d_addr, wen, wmask, wdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata, rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, d_addr, wen, wmask, wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator turning one core request into one or two word accesses.
// Macro MISALIGNED_SPLIT_EN: split 4-byte-crossing accesses; otherwise fault them.
module mem_access_unit #(
  parameter int WORD_LEN = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ST0, ST1, LD0, LD1, LD2, RESP} state_t;

  state_t              state_r;
  logic [WORD_LEN-1:0] base_r;
  logic [WORD_LEN-1:0] hi_data_r;
  logic [WORD_LEN-1:0] word0_r;
  logic [WORD_LEN-1:0] d_addr_r;
  logic [WORD_LEN-1:0] wmask_r;
  logic [WORD_LEN-1:0] wdata_r;
  logic [WORD_LEN-1:0] resp_rdata_r;
  logic [3:0]          hi_mask_r;
  logic [1:0]          off_r;
  logic [1:0]          size_r;
  logic                uns_r;
  logic                cross_r;
  logic                wen_r;
  logic                resp_valid_r;
  logic                resp_misaligned_r;

  logic [31:0] req_base_s;
  logic [1:0]  req_off_s;
  logic [7:0]  req_m8_s;
  logic [63:0] req_w64_s;
  logic        req_cross_s;

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      default: m = 8'h0f;
    endcase
    return m << off;
  endfunction

  function automatic logic is_cross(input logic [1:0] size, input logic [1:0] off);
    logic [2:0] nb;
    case (size)
      2'd0:    nb = 3'd1;
      2'd1:    nb = 3'd2;
      default: nb = 3'd4;
    endcase
    return ({1'b0, off} + nb) > 3'd4;
  endfunction

  function automatic logic [31:0] expand_lanes(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  // pair = {word1, word0}; the addressed bytes start at lane off of word0
  function automatic logic [31:0] load_result(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] r;
    r = 32'(pair >> {off, 3'b000});
    case (size)
      2'd0:    load_result = uns ? {24'h000000, r[7:0]} : {{24{r[7]}}, r[7:0]};
      2'd1:    load_result = uns ? {16'h0000, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default: load_result = r;
    endcase
  endfunction

  // Decode the request presented by the core
  always_comb begin
    req_off_s   = bus.req_addr[1:0];
    req_base_s  = {bus.req_addr[31:2], 2'b00};
    req_m8_s    = lane_mask(bus.req_size, req_off_s);
    req_w64_s   = {32'h00000000, bus.req_wdata} << {req_off_s, 3'b000};
    req_cross_s = is_cross(bus.req_size, req_off_s);
  end

  assign bus.req_ready       = (state_r == IDLE) && !rst;
  assign bus.resp_valid      = resp_valid_r;
  assign bus.resp_rdata      = resp_rdata_r;
  assign bus.resp_misaligned = resp_misaligned_r;
  assign bus.d_addr          = d_addr_r;
  assign bus.wen             = wen_r;
  assign bus.wmask           = wmask_r;
  assign bus.wdata           = wdata_r;

  // Access sequencer with registered memory-side and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      base_r            <= 32'h00000000;
      hi_data_r         <= 32'h00000000;
      word0_r           <= 32'h00000000;
      hi_mask_r         <= 4'h0;
      off_r             <= 2'd0;
      size_r            <= 2'd0;
      uns_r             <= 1'b0;
      cross_r           <= 1'b0;
      d_addr_r          <= 32'h00000000;
      wen_r             <= 1'b0;
      wmask_r           <= 32'h00000000;
      wdata_r           <= 32'h00000000;
      resp_valid_r      <= 1'b0;
      resp_rdata_r      <= 32'h00000000;
      resp_misaligned_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            base_r    <= req_base_s;
            off_r     <= req_off_s;
            size_r    <= bus.req_size;
            uns_r     <= bus.req_unsigned;
            cross_r   <= req_cross_s;
            hi_mask_r <= req_m8_s[7:4];
            hi_data_r <= req_w64_s[63:32];
`ifndef MISALIGNED_SPLIT_EN
            if (req_cross_s) begin
              resp_valid_r      <= 1'b1;
              resp_misaligned_r <= 1'b1;
              resp_rdata_r      <= 32'h00000000;
              state_r           <= RESP;
            end else
`endif
            begin
              d_addr_r <= req_base_s;
              if (bus.req_wen) begin
                wen_r   <= 1'b1;
                wmask_r <= expand_lanes(req_m8_s[3:0]);
                wdata_r <= req_w64_s[31:0];
                state_r <= ST0;
              end else begin
                state_r <= LD0;
              end
            end
          end
        end
        ST0: begin
          if (cross_r) begin
            d_addr_r <= base_r + 32'd4;
            wmask_r  <= expand_lanes(hi_mask_r);
            wdata_r  <= hi_data_r;
            state_r  <= ST1;
          end else begin
            wen_r        <= 1'b0;
            wmask_r      <= 32'h00000000;
            wdata_r      <= 32'h00000000;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= 32'h00000000;
            state_r      <= RESP;
          end
        end
        ST1: begin
          wen_r        <= 1'b0;
          wmask_r      <= 32'h00000000;
          wdata_r      <= 32'h00000000;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 32'h00000000;
          state_r      <= RESP;
        end
        LD0: begin
          if (cross_r) begin
            d_addr_r <= base_r + 32'd4;
          end
          state_r <= LD1;
        end
        LD1: begin
          if (cross_r) begin
            word0_r <= bus.rdata;
            state_r <= LD2;
          end else begin
            resp_rdata_r <= load_result({32'h00000000, bus.rdata}, off_r, size_r, uns_r);
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end
        end
        LD2: begin
          resp_rdata_r <= load_result({bus.rdata, word0_r}, off_r, size_r, uns_r);
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          resp_valid_r      <= 1'b0;
          resp_misaligned_r <= 1'b0;
          resp_rdata_r      <= 32'h00000000;
          state_r           <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, hand sequences, random vs byte model.
// Honours MISALIGNED_SPLIT_EN the same way as the design.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.WORD_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int bad_lane = 0;

  logic [7:0] mem     [0:63];
  logic [7:0] ref_mem [0:63];

  // Word memory: 1-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (bus.wen) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wmask[8*i +: 8] == 8'hff) mem[{bus.d_addr[5:2], 2'(i)}] <= bus.wdata[8*i +: 8];
        else if (bus.wmask[8*i +: 8] != 8'h00) bad_lane++;
      end
    end
    bus.rdata <= {mem[{bus.d_addr[5:2], 2'd3}], mem[{bus.d_addr[5:2], 2'd2}],
                  mem[{bus.d_addr[5:2], 2'd1}], mem[{bus.d_addr[5:2], 2'd0}]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload();
    logic [7:0] init8 [0:7];
    init8 = '{8'hbe, 8'hbe, 8'hfe, 8'hca, 8'hef, 8'hbe, 8'had, 8'hde};
    for (int i = 0; i < 64; i++) begin
      mem[i]     = (i < 8) ? init8[i] : 8'(i * 37 + 5);
      ref_mem[i] = mem[i];
    end
  endtask

  // Per-request observation, one entry per cycle after accept
  logic [31:0] tr_addr [1:12];
  logic [31:0] tr_mask [1:12];
  logic [31:0] tr_data [1:12];
  logic        tr_wen  [1:12];
  int          lat;
  int          wen_cnt;
  logic [31:0] got_rd;
  logic        got_mis;
  logic        rdy_at_resp;

  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd);
    int k;
    bus.req_valid = 1'b1; bus.req_wen = w; bus.req_addr = a;
    bus.req_size = sz; bus.req_unsigned = u; bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd);
    bit done;
    issue(w, a, sz, u, wd);
    lat = 0; wen_cnt = 0; done = 0; got_rd = 32'hx; got_mis = 1'bx; rdy_at_resp = 1'bx;
    for (int c = 1; c <= 12 && !done; c++) begin
      tr_addr[c] = bus.d_addr; tr_mask[c] = bus.wmask;
      tr_data[c] = bus.wdata;  tr_wen[c]  = bus.wen;
      if (bus.wen) wen_cnt++;
      if (bus.resp_valid) begin
        done = 1; lat = c; got_rd = bus.resp_rdata;
        got_mis = bus.resp_misaligned; rdy_at_resp = bus.req_ready;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Byte-level reference: what the core should observe and how memory should change
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, output logic [31:0] rd,
                       output logic mis, output int elat, output int nw);
    int nb;
    bit cr;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    cr = (int'(a[1:0]) + nb) > 4;
    rd = 32'h0; mis = 1'b0; elat = 0; nw = 0;
`ifndef MISALIGNED_SPLIT_EN
    if (cr) begin mis = 1'b1; elat = 1; return; end
`endif
    if (w) begin
      for (int i = 0; i < nb; i++) ref_mem[6'(a + 32'(i))] = wd[8*i +: 8];
      elat = cr ? 3 : 2;
      nw   = cr ? 2 : 1;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | ({24'h0, ref_mem[6'(a + 32'(i))]} << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hffffffff << (8 * nb));
      rd = v;
      elat = cr ? 4 : 3;
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t ld(input logic [31:0] a, input logic [1:0] sz, input logic u,
                              input logic [31:0] rd, input logic mis, input int l);
    vec_t v;
    v = '{1'b0, a, sz, u, 32'h0, rd, mis, l};
    return v;
  endfunction

  task automatic check_mem(input string name);
    int diff;
    diff = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk(name, 32'(diff), 32'd0);
  endtask

  logic [31:0] e_rd;
  logic        e_mis;
  int          e_lat;
  int          e_nw;
  int          seen;

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = 32'h0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.req_wdata = 32'h0;
    preload();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_misaligned", 32'(bus.resp_misaligned), 32'd0);
    chk("rst_d_addr", bus.d_addr, 32'h0);
    chk("rst_wen", 32'(bus.wen), 32'd0);
    chk("rst_wmask", bus.wmask, 32'h0);
    chk("rst_wdata", bus.wdata, 32'h0);
    rst = 1'b0;
    #1 chk("ready_after_rst", 32'(bus.req_ready), 32'd1);
    @(negedge clk);

    // Load vectors against the preload pattern
    vt.push_back(ld(32'd0, 2'd2, 1'b0, 32'hcafebebe, 1'b0, 3));
    vt.push_back(ld(32'd3, 2'd0, 1'b0, 32'hffffffca, 1'b0, 3));
    vt.push_back(ld(32'd3, 2'd0, 1'b1, 32'h000000ca, 1'b0, 3));
    vt.push_back(ld(32'd2, 2'd1, 1'b0, 32'hffffcafe, 1'b0, 3));
    vt.push_back(ld(32'd2, 2'd1, 1'b1, 32'h0000cafe, 1'b0, 3));
    vt.push_back(ld(32'd4, 2'd2, 1'b0, 32'hdeadbeef, 1'b0, 3));
    vt.push_back(ld(32'd4, 2'd3, 1'b1, 32'hdeadbeef, 1'b0, 3));
    vt.push_back(ld(32'd7, 2'd0, 1'b0, 32'hffffffde, 1'b0, 3));
    vt.push_back(ld(32'd5, 2'd0, 1'b1, 32'h000000be, 1'b0, 3));
    vt.push_back(ld(32'd6, 2'd1, 1'b0, 32'hffffdead, 1'b0, 3));
    vt.push_back(ld(32'd4, 2'd1, 1'b1, 32'h0000beef, 1'b0, 3));
`ifdef MISALIGNED_SPLIT_EN
    vt.push_back(ld(32'd1, 2'd2, 1'b0, 32'hefcafebe, 1'b0, 4));
    vt.push_back(ld(32'd3, 2'd1, 1'b0, 32'hffffefca, 1'b0, 4));
    vt.push_back(ld(32'd3, 2'd1, 1'b1, 32'h0000efca, 1'b0, 4));
`else
    vt.push_back(ld(32'd1, 2'd2, 1'b0, 32'h00000000, 1'b1, 1));
    vt.push_back(ld(32'd2, 2'd2, 1'b0, 32'h00000000, 1'b1, 1));
    vt.push_back(ld(32'd3, 2'd1, 1'b0, 32'h00000000, 1'b1, 1));
`endif
    foreach (vt[i]) begin
      run_req(vt[i].w, vt[i].addr, vt[i].sz, vt[i].u, vt[i].wd);
      chk($sformatf("vec%0d_rdata", i), got_rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_misaligned", i), 32'(got_mis), 32'(vt[i].exp_mis));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_wen_cycles", i), 32'(wen_cnt), 32'd0);
    end

    run_req(1'b0, 32'd0, 2'd2, 1'b0, 32'h0);
    chk("lw0_d_addr_t1", tr_addr[1], 32'h0);
`ifdef MISALIGNED_SPLIT_EN
    run_req(1'b0, 32'd1, 2'd2, 1'b0, 32'h0);
    chk("lw1_d_addr_t1", tr_addr[1], 32'h0);
    chk("lw1_d_addr_t2", tr_addr[2], 32'h4);

    run_req(1'b1, 32'd3, 2'd2, 1'b0, 32'h11223344);
    chk("sw3_t1_wen", 32'(tr_wen[1]), 32'd1);
    chk("sw3_t1_addr", tr_addr[1], 32'h0);
    chk("sw3_t1_mask", tr_mask[1], 32'hff000000);
    chk("sw3_t1_data", tr_data[1], 32'h44000000);
    chk("sw3_t2_wen", 32'(tr_wen[2]), 32'd1);
    chk("sw3_t2_addr", tr_addr[2], 32'h4);
    chk("sw3_t2_mask", tr_mask[2], 32'h00ffffff);
    chk("sw3_t2_data", tr_data[2], 32'h00112233);
    chk("sw3_latency", 32'(lat), 32'd3);
    chk("sw3_bytes", {mem[6], mem[5], mem[4], mem[3]}, 32'h11223344);
`else
    run_req(1'b1, 32'd3, 2'd1, 1'b0, 32'h0000abcd);
    chk("sh3_misaligned", 32'(got_mis), 32'd1);
    chk("sh3_latency", 32'(lat), 32'd1);
    chk("sh3_wen_cycles", 32'(wen_cnt), 32'd0);
    chk("sh3_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'hcafebebe);
    chk("sh3_word1", {mem[7], mem[6], mem[5], mem[4]}, 32'hdeadbeef);
    run_req(1'b1, 32'd2, 2'd1, 1'b0, 32'h00005566);
    chk("sh2_addr", tr_addr[1], 32'h0);
    chk("sh2_mask", tr_mask[1], 32'hffff0000);
    chk("sh2_data", tr_data[1], 32'h55660000);
    chk("sh2_misaligned", 32'(got_mis), 32'd0);
    chk("sh2_latency", 32'(lat), 32'd2);
    chk("sh2_word0", {mem[3], mem[2], mem[1], mem[0]}, 32'h5566bebe);
`endif

    // Reset in the cycle after accept aborts the request
    preload();
`ifdef MISALIGNED_SPLIT_EN
    issue(1'b1, 32'd1, 2'd2, 1'b0, 32'h11223344);
`else
    issue(1'b0, 32'd0, 2'd2, 1'b0, 32'h0);
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wen", 32'(bus.wen), 32'd0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_ready_in_rst", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    #1 chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wen || bus.resp_valid) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    chk("abort_word4", {mem[7], mem[6], mem[5], mem[4]}, 32'hdeadbeef);

    // Random traffic against the byte model
    preload();
    for (int n = 0; n < 300; n++) begin
      logic w, u;
      logic [31:0] a, wd;
      logic [1:0] sz;
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
      a = $urandom; wd = $urandom; sz = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(w, a, sz, u, wd, e_rd, e_mis, e_lat, e_nw);
      run_req(w, a, sz, u, wd);
      chk($sformatf("rnd%0d_rdata", n), got_rd, e_rd);
      chk($sformatf("rnd%0d_misaligned", n), 32'(got_mis), 32'(e_mis));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_wen_cycles", n), 32'(wen_cnt), 32'(e_nw));
      chk($sformatf("rnd%0d_ready_in_resp", n), 32'(rdy_at_resp), 32'd0);
      if (w) begin
        @(negedge clk);
        check_mem($sformatf("rnd%0d_memory", n));
      end
    end
    check_mem("final_memory");
    chk("lane_mask_form", 32'(bad_lane), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
